// File: rtl/heap_pq_pkg.sv
// rtl/heap_pq_pkg.sv - shared opcodes, FSM states and width helpers for heap_pq
package heap_pq_pkg;

  typedef enum logic [2:0] {
    OP_CLEAR   = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_PEEK    = 3'd3,
    OP_REPLACE = 3'd4
  } op_code_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SIFT_UP   = 2'd1,
    ST_SIFT_DOWN = 2'd2
  } state_e;

  // Width of the occupancy counter: must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a heap index; one spare bit so child arithmetic has headroom.
  function automatic int idx_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/heap_pq_better.sv
// rtl/heap_pq_better.sv - strict heap ordering compare between two keys
//
// Ports:
//   a, b    keys to compare (unsigned)
//   better  1 when a must sit above b: a > b for a max-heap, a < b for a
//           min-heap. Equal keys are never "better", so ties never swap.
module heap_pq_better #(
  parameter int DATA_W   = 32,
  parameter int MIN_HEAP = 0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              better
);

  always_comb begin
    if (MIN_HEAP != 0) better = (a < b);
    else               better = (a > b);
  end

endmodule

// File: rtl/heap_pq.sv
// rtl/heap_pq.sv - binary-heap priority queue, one compare-swap per clock
//
// Optional feature macro: HEAP_PQ_REPLACE_EN enables op_code 4 (replace root).
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   op_valid/op_ready     command handshake (ready only while IDLE)
//   op_code, op_data      0 clear, 1 push, 2 pop, 3 peek, 4 replace; key
//   rsp_valid             one-cycle pulse per accepted command
//   rsp_data, rsp_err     root key for pop/peek/replace (else 0); rejected
//   count, empty, full    occupancy status
module heap_pq
  import heap_pq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int MIN_HEAP = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic [2:0]                    op_code,
  input  logic [DATA_W-1:0]             op_data,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_data,
  output logic                          rsp_err,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          empty,
  output logic                          full
);

  localparam int CW = cnt_width(DEPTH);
  localparam int IW = idx_width(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = IW + 1;  // child arithmetic: 2*idx+2 for idx = DEPTH-1

  logic [DATA_W-1:0] heap [DEPTH];

  state_e            state, state_n;
  logic [IW-1:0]     idx, idx_n;
  logic [CW-1:0]     count_n;
  logic              rsp_valid_n, rsp_err_n;
  logic [DATA_W-1:0] rsp_data_n;

  // Single-entry write (push/pop/replace) and two-entry swap (sifting) are
  // never active in the same cycle.
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              swap_en;
  logic [AW-1:0]     swap_a, swap_b;

  // Sift neighbourhood of the current index.
  logic [IW-1:0]     par;
  logic [EW-1:0]     idx_e, l_idx, r_idx, cnt_e;
  logic              l_valid, r_valid, r_pick;
  logic [IW-1:0]     child;
  logic [DATA_W-1:0] cur_key, par_key, l_key, r_key, child_key;
  logic              up_better, r_better, down_better;

  assign op_ready = (state == ST_IDLE);
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));

  assign par     = (idx - IW'(1)) >> 1;
  assign idx_e   = EW'(idx);
  assign l_idx   = (idx_e << 1) + EW'(1);
  assign r_idx   = (idx_e << 1) + EW'(2);
  assign cnt_e   = EW'(count);
  assign l_valid = (l_idx < cnt_e);
  assign r_valid = (r_idx < cnt_e);

  assign cur_key = heap[AW'(idx)];
  assign par_key = heap[AW'(par)];
  assign l_key   = heap[AW'(l_idx)];
  assign r_key   = heap[AW'(r_idx)];

  heap_pq_better #(.DATA_W(DATA_W), .MIN_HEAP(MIN_HEAP)) u_up (
    .a(cur_key), .b(par_key), .better(up_better)
  );

  heap_pq_better #(.DATA_W(DATA_W), .MIN_HEAP(MIN_HEAP)) u_pick (
    .a(r_key), .b(l_key), .better(r_better)
  );

  // Right child wins only when strictly better, so ties favour the left.
  assign r_pick    = r_valid && r_better;
  assign child     = r_pick ? IW'(r_idx) : IW'(l_idx);
  assign child_key = r_pick ? r_key : l_key;

  heap_pq_better #(.DATA_W(DATA_W), .MIN_HEAP(MIN_HEAP)) u_down (
    .a(child_key), .b(cur_key), .better(down_better)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      count     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      count     <= count_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
      rsp_data  <= rsp_data_n;
    end
  end

  // Storage is intentionally not reset; entries at or beyond count are
  // don't-care.
  always_ff @(posedge clk) begin
    if (wr_en) heap[wr_addr] <= wr_data;
    if (swap_en) begin
      heap[swap_a] <= heap[swap_b];
      heap[swap_b] <= heap[swap_a];
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    count_n     = count;
    rsp_valid_n = 1'b0;
    rsp_err_n   = 1'b0;
    rsp_data_n  = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    swap_en     = 1'b0;
    swap_a      = '0;
    swap_b      = '0;

    case (state)
      ST_IDLE: begin
        if (op_valid) begin
          rsp_valid_n = 1'b1;
          case (op_code)
            OP_CLEAR: count_n = '0;
            OP_PUSH: begin
              if (full) begin
                rsp_err_n = 1'b1;
              end else begin
                wr_en   = 1'b1;
                wr_addr = AW'(count);
                wr_data = op_data;
                count_n = count + CW'(1);
                if (count != '0) begin
                  state_n = ST_SIFT_UP;
                  idx_n   = IW'(count);
                end
              end
            end
            OP_POP: begin
              if (empty) begin
                rsp_err_n = 1'b1;
              end else begin
                rsp_data_n = heap[0];
                wr_en      = 1'b1;
                wr_addr    = '0;
                wr_data    = heap[AW'(count - CW'(1))];
                count_n    = count - CW'(1);
                // Only sift when at least two entries remain.
                if (count > CW'(2)) begin
                  state_n = ST_SIFT_DOWN;
                  idx_n   = '0;
                end
              end
            end
            OP_PEEK: begin
              if (empty) rsp_err_n  = 1'b1;
              else       rsp_data_n = heap[0];
            end
`ifdef HEAP_PQ_REPLACE_EN
            OP_REPLACE: begin
              if (empty) begin
                rsp_err_n = 1'b1;
              end else begin
                rsp_data_n = heap[0];
                wr_en      = 1'b1;
                wr_addr    = '0;
                wr_data    = op_data;
                if (count != CW'(1)) begin
                  state_n = ST_SIFT_DOWN;
                  idx_n   = '0;
                end
              end
            end
`endif
            default: rsp_err_n = 1'b1;
          endcase
        end
      end

      ST_SIFT_UP: begin
        if (idx == '0 || !up_better) begin
          state_n = ST_IDLE;
        end else begin
          swap_en = 1'b1;
          swap_a  = AW'(idx);
          swap_b  = AW'(par);
          idx_n   = par;
        end
      end

      ST_SIFT_DOWN: begin
        if (!l_valid || !down_better) begin
          state_n = ST_IDLE;
        end else begin
          swap_en = 1'b1;
          swap_a  = AW'(idx);
          swap_b  = AW'(child);
          idx_n   = child;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_heap_pq.sv
// tb/tb_heap_pq.sv - directed self-checking bench for heap_pq (max and min instances)
module tb_heap_pq;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int MAXB  = 4;  // log2(DEPTH) + 1

  localparam logic [2:0] C_CLEAR = 3'd0;
  localparam logic [2:0] C_PUSH  = 3'd1;
  localparam logic [2:0] C_POP   = 3'd2;
  localparam logic [2:0] C_PEEK  = 3'd3;
  localparam logic [2:0] C_REPL  = 3'd4;

  logic          clk;
  logic          reset;
  logic          op_valid  [2];
  logic          op_ready  [2];
  logic [2:0]    op_code   [2];
  logic [DW-1:0] op_data   [2];
  logic          rsp_valid [2];
  logic [DW-1:0] rsp_data  [2];
  logic          rsp_err   [2];
  logic [3:0]    count     [2];
  logic          empty     [2];
  logic          full      [2];

  int vectors;
  int miscompares;

  heap_pq #(.DATA_W(DW), .DEPTH(DEPTH), .MIN_HEAP(0)) u_max (
    .clk(clk), .reset(reset),
    .op_valid(op_valid[0]), .op_ready(op_ready[0]), .op_code(op_code[0]),
    .op_data(op_data[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
    .rsp_err(rsp_err[0]), .count(count[0]), .empty(empty[0]), .full(full[0])
  );

  heap_pq #(.DATA_W(DW), .DEPTH(DEPTH), .MIN_HEAP(1)) u_min (
    .clk(clk), .reset(reset),
    .op_valid(op_valid[1]), .op_ready(op_ready[1]), .op_code(op_code[1]),
    .op_data(op_data[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
    .rsp_err(rsp_err[1]), .count(count[1]), .empty(empty[1]), .full(full[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Drive one command, return the response sampled 1ns after acceptance and
  // the number of cycles op_ready stayed low afterwards.
  task automatic do_op(input int d, input logic [2:0] code, input logic [DW-1:0] data,
                       output logic v, output logic e, output logic [DW-1:0] rd,
                       output int busy);
    int n;
    n = 0;
    while (!op_ready[d] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!op_ready[d]) begin
      vectors++; miscompares++;
      $display("FAIL ready_wait dut=%0d op_ready stuck low", d);
    end
    @(negedge clk);
    op_valid[d] = 1'b1;
    op_code[d]  = code;
    op_data[d]  = data;
    @(posedge clk); #1;
    op_valid[d] = 1'b0;
    v  = rsp_valid[d];
    e  = rsp_err[d];
    rd = rsp_data[d];
    busy = 0;
    while (!op_ready[d] && busy < 50) begin
      @(posedge clk); #1; busy++;
    end
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (op_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_data[d] !== '0 ||
          rsp_err[d] !== 1'b0 || count[d] !== 4'd0 || empty[d] !== 1'b1 || full[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset dut=%0d got rdy=%b v=%b d=%0d e=%b cnt=%0d em=%b fu=%b want 1 0 0 0 0 1 0",
                 d, op_ready[d], rsp_valid[d], rsp_data[d], rsp_err[d], count[d], empty[d], full[d]);
      end
    end
  endtask

  task automatic test_empty_errors;
    logic v, e; logic [DW-1:0] rd; int b;
    logic [2:0] codes [2];
    codes[0] = C_POP; codes[1] = C_PEEK;
    for (int i = 0; i < 2; i++) begin
      do_op(0, codes[i], '0, v, e, rd, b);
      vectors++;
      if (v !== 1'b1 || e !== 1'b1 || rd !== '0 || count[0] !== 4'd0) begin
        miscompares++;
        $display("FAIL empty_err op=%0d got v=%b e=%b d=%0d cnt=%0d want v=1 e=1 d=0 cnt=0",
                 codes[i], v, e, rd, count[0]);
      end
    end
  endtask

  task automatic test_max_order;
    logic v, e; logic [DW-1:0] rd; int b;
    logic [DW-1:0] pv [4];
    logic [DW-1:0] ex [4];
    pv[0] = 5; pv[1] = 3; pv[2] = 9; pv[3] = 1;
    ex[0] = 9; ex[1] = 5; ex[2] = 3; ex[3] = 1;
    for (int i = 0; i < 4; i++) begin
      do_op(0, C_PUSH, pv[i], v, e, rd, b);
      vectors++;
      if (v !== 1'b1 || e !== 1'b0 || rd !== '0 || count[0] !== 4'(i + 1)) begin
        miscompares++;
        $display("FAIL max_push %0d got v=%b e=%b d=%0d cnt=%0d want v=1 e=0 d=0 cnt=%0d",
                 i, v, e, rd, count[0], i + 1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      do_op(0, C_POP, '0, v, e, rd, b);
      vectors++;
      if (v !== 1'b1 || e !== 1'b0 || rd !== ex[i] || count[0] !== 4'(3 - i)) begin
        miscompares++;
        $display("FAIL max_pop %0d got d=%0d e=%b cnt=%0d want d=%0d e=0 cnt=%0d",
                 i, rd, e, count[0], ex[i], 3 - i);
      end
    end
    vectors++;
    if (empty[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL max_empty got %b want 1", empty[0]);
    end
  endtask

  task automatic test_illegal_and_clear;
    logic v, e; logic [DW-1:0] rd; int b;
    do_op(0, C_PUSH, 16'd42, v, e, rd, b);
    do_op(0, 3'd5, 16'd7, v, e, rd, b);
    vectors++;
    if (v !== 1'b1 || e !== 1'b1 || count[0] !== 4'd1) begin
      miscompares++;
      $display("FAIL illegal5 got v=%b e=%b cnt=%0d want 1 1 1", v, e, count[0]);
    end
    do_op(0, 3'd7, 16'd7, v, e, rd, b);
    vectors++;
    if (e !== 1'b1 || count[0] !== 4'd1) begin
      miscompares++;
      $display("FAIL illegal7 got e=%b cnt=%0d want 1 1", e, count[0]);
    end
    do_op(0, C_PEEK, '0, v, e, rd, b);
    vectors++;
    if (e !== 1'b0 || rd !== 16'd42 || b !== 0) begin
      miscompares++;
      $display("FAIL peek_one got e=%b d=%0d busy=%0d want 0 42 0", e, rd, b);
    end
    do_op(0, C_CLEAR, '0, v, e, rd, b);
    vectors++;
    if (v !== 1'b1 || e !== 1'b0 || rd !== '0 || count[0] !== 4'd0 || empty[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL clear got v=%b e=%b d=%0d cnt=%0d em=%b want 1 0 0 0 1",
               v, e, rd, count[0], empty[0]);
    end
  endtask

  task automatic test_replace;
    logic v, e; logic [DW-1:0] rd; int b;
    do_op(0, C_PUSH, 16'd10, v, e, rd, b);
    do_op(0, C_PUSH, 16'd4,  v, e, rd, b);
    do_op(0, C_PUSH, 16'd6,  v, e, rd, b);
`ifdef HEAP_PQ_REPLACE_EN
    begin
      logic [DW-1:0] ex [3];
      ex[0] = 6; ex[1] = 4; ex[2] = 1;
      do_op(0, C_REPL, 16'd1, v, e, rd, b);
      vectors++;
      if (v !== 1'b1 || e !== 1'b0 || rd !== 16'd10 || count[0] !== 4'd3) begin
        miscompares++;
        $display("FAIL replace got v=%b e=%b d=%0d cnt=%0d want 1 0 10 3", v, e, rd, count[0]);
      end
      for (int i = 0; i < 3; i++) begin
        do_op(0, C_POP, '0, v, e, rd, b);
        vectors++;
        if (e !== 1'b0 || rd !== ex[i]) begin
          miscompares++;
          $display("FAIL replace_pop %0d got d=%0d e=%b want d=%0d e=0", i, rd, e, ex[i]);
        end
      end
    end
`else
    do_op(0, C_REPL, 16'd1, v, e, rd, b);
    vectors++;
    if (v !== 1'b1 || e !== 1'b1 || rd !== '0 || count[0] !== 4'd3) begin
      miscompares++;
      $display("FAIL replace_off got v=%b e=%b d=%0d cnt=%0d want 1 1 0 3", v, e, rd, count[0]);
    end
    do_op(0, C_POP, '0, v, e, rd, b);
    vectors++;
    if (rd !== 16'd10) begin
      miscompares++;
      $display("FAIL replace_off_pop got %0d want 10", rd);
    end
    do_op(0, C_CLEAR, '0, v, e, rd, b);
`endif
  endtask

  task automatic test_min_ties;
    logic v, e; logic [DW-1:0] rd; int b;
    logic [DW-1:0] pv [3];
    logic [DW-1:0] ex [3];
    int worst;
    pv[0] = 7; pv[1] = 7; pv[2] = 2;
    ex[0] = 2; ex[1] = 7; ex[2] = 7;
    worst = 0;
    for (int i = 0; i < 3; i++) begin
      do_op(1, C_PUSH, pv[i], v, e, rd, b);
      if (b > worst) worst = b;
    end
    vectors++;
    if (count[1] !== 4'd3) begin
      miscompares++;
      $display("FAIL min_count got %0d want 3", count[1]);
    end
    for (int i = 0; i < 3; i++) begin
      do_op(1, C_POP, '0, v, e, rd, b);
      if (b > worst) worst = b;
      vectors++;
      if (v !== 1'b1 || e !== 1'b0 || rd !== ex[i]) begin
        miscompares++;
        $display("FAIL min_pop %0d got d=%0d e=%b want d=%0d e=0", i, rd, e, ex[i]);
      end
    end
    vectors++;
    if (worst > MAXB) begin
      miscompares++;
      $display("FAIL min_busy got %0d want <= %0d", worst, MAXB);
    end
  endtask

  task automatic test_full;
    logic v, e; logic [DW-1:0] rd; int b;
    int worst;
    worst = 0;
    for (int i = 1; i <= 8; i++) begin
      do_op(0, C_PUSH, DW'(i), v, e, rd, b);
      if (b > worst) worst = b;
      vectors++;
      if (e !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_push %0d got e=%b want 0", i, e);
      end
    end
    vectors++;
    if (worst > MAXB || full[0] !== 1'b1 || count[0] !== 4'd8) begin
      miscompares++;
      $display("FAIL fill got busy=%0d full=%b cnt=%0d want <=%0d 1 8", worst, full[0], count[0], MAXB);
    end
    do_op(0, C_PUSH, 16'd9, v, e, rd, b);
    vectors++;
    if (v !== 1'b1 || e !== 1'b1 || full[0] !== 1'b1 || count[0] !== 4'd8) begin
      miscompares++;
      $display("FAIL push_full got v=%b e=%b full=%b cnt=%0d want 1 1 1 8", v, e, full[0], count[0]);
    end
    do_op(0, C_PEEK, '0, v, e, rd, b);
    vectors++;
    if (e !== 1'b0 || rd !== 16'd8) begin
      miscompares++;
      $display("FAIL peek_full got e=%b d=%0d want 0 8", e, rd);
    end
  endtask

  task automatic test_reset_mid_sift;
    logic v, e; logic [DW-1:0] rd; int b;
    @(negedge clk);
    op_valid[0] = 1'b1;
    op_code[0]  = C_POP;
    @(posedge clk); #1;
    op_valid[0] = 1'b0;
    vectors++;
    if (op_ready[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL sift_busy got op_ready=%b want 0", op_ready[0]);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (op_ready[0] !== 1'b1 || count[0] !== 4'd0 || rsp_valid[0] !== 1'b0 || empty[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_abort got rdy=%b cnt=%0d v=%b em=%b want 1 0 0 1",
               op_ready[0], count[0], rsp_valid[0], empty[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    do_op(0, C_POP, '0, v, e, rd, b);
    vectors++;
    if (v !== 1'b1 || e !== 1'b1 || rd !== '0) begin
      miscompares++;
      $display("FAIL pop_after_reset got v=%b e=%b d=%0d want 1 1 0", v, e, rd);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      op_valid[d] = 1'b0;
      op_code[d]  = '0;
      op_data[d]  = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    test_reset();
    test_empty_errors();
    test_max_order();
    test_illegal_and_clear();
    test_replace();
    test_min_ties();
    test_full();
    test_reset_mid_sift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
